// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing the single genrom read port between core fetch (port 0) and a host reader (port 1).
// Define ROM_ARBITER_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module rom_arbiter #(
  parameter  int MEM_ADDR  = 6,
  parameter  int MEM_EXTRA = 4,
  localparam int AW        = MEM_ADDR + 1,
  localparam int DW        = (2 ** MEM_EXTRA) * 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic [AW-1:0]        p0_addr,
  input  logic [MEM_EXTRA-1:0] p0_extra,
  input  logic [AW-1:0]        p0_lower,
  input  logic [AW-1:0]        p0_upper,
  output logic                 p0_ack,
  output logic [DW-1:0]        p0_data,
  output logic                 p0_error,
  input  logic                 p1_req,
  input  logic [AW-1:0]        p1_addr,
  input  logic [MEM_EXTRA-1:0] p1_extra,
  input  logic [AW-1:0]        p1_lower,
  input  logic [AW-1:0]        p1_upper,
  output logic                 p1_ack,
  output logic [DW-1:0]        p1_data,
  output logic                 p1_error,
  output logic [AW-1:0]        mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  output logic [AW-1:0]        mem_lower_bound,
  output logic [AW-1:0]        mem_upper_bound,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_error,
  output logic                 busy,
  output logic                 grant
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t state, state_next;
  logic   do_grant;
  logic   pick;
  logic   arb_pick;
  logic   handoff;

`ifdef ROM_ARBITER_ROUND_ROBIN_EN
  logic last_served;

  // A tie goes to the port not served last; a lone request simply wins.
  assign arb_pick = (p0_req && p1_req) ? ~last_served : p1_req;
  assign handoff  = grant ? p0_req : p1_req;
`else
  assign arb_pick = ~p0_req;
  // After serving port 0, port 1 may only take over if port 0 is not asking again.
  assign handoff  = grant ? p0_req : (p1_req && !p0_req);
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_next = state;
    do_grant   = 1'b0;
    pick       = grant;
    case (state)
      S_IDLE: begin
        if (p0_req || p1_req) begin
          do_grant   = 1'b1;
          pick       = arb_pick;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  state_next = S_ACK;
      S_ACK: begin
        state_next = S_IDLE;
        if (handoff) begin
          do_grant   = 1'b1;
          pick       = ~grant;
          state_next = S_ISSUE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      grant           <= 1'b0;
      mem_addr        <= '0;
      mem_extra       <= '0;
      mem_lower_bound <= '0;
      mem_upper_bound <= '0;
      p0_data         <= '0;
      p0_error        <= 1'b0;
      p1_data         <= '0;
      p1_error        <= 1'b0;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
      last_served     <= 1'b1;
`endif
    end else begin
      state <= state_next;
      if (do_grant) begin
        grant           <= pick;
        mem_addr        <= pick ? p1_addr  : p0_addr;
        mem_extra       <= pick ? p1_extra : p0_extra;
        mem_lower_bound <= pick ? p1_lower : p0_lower;
        mem_upper_bound <= pick ? p1_upper : p0_upper;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
        last_served     <= pick;
`endif
      end
      // Only the granted port's response registers move; the other port holds its last result.
      if (state == S_WAIT) begin
        if (grant) begin
          p1_data  <= mem_data;
          p1_error <= mem_error;
        end else begin
          p0_data  <= mem_data;
          p0_error <= mem_error;
        end
      end
    end
  end

  assign p0_ack = (state == S_ACK) && !grant;
  assign p1_ack = (state == S_ACK) &&  grant;
  assign busy   = (state != S_IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a registered byte[k]=k ROM model.
module tb_rom_arbiter;

  localparam int AW = 7;
  localparam int EW = 4;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p1_req;
  logic [AW-1:0] p0_addr, p1_addr, p0_lower, p1_lower, p0_upper, p1_upper;
  logic [EW-1:0] p0_extra, p1_extra;
  logic          p0_ack, p1_ack, p0_error, p1_error;
  logic [DW-1:0] p0_data, p1_data;
  logic [AW-1:0] mem_addr, mem_lower_bound, mem_upper_bound;
  logic [EW-1:0] mem_extra;
  logic [DW-1:0] mem_data;
  logic          mem_error;
  logic          busy, grant;

  int checks   = 0;
  int failures = 0;
  int lat;

  rom_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_extra(p0_extra), .p0_lower(p0_lower), .p0_upper(p0_upper),
    .p0_ack(p0_ack), .p0_data(p0_data), .p0_error(p0_error),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_extra(p1_extra), .p1_lower(p1_lower), .p1_upper(p1_upper),
    .p1_ack(p1_ack), .p1_data(p1_data), .p1_error(p1_error),
    .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_lower_bound(mem_lower_bound), .mem_upper_bound(mem_upper_bound),
    .mem_data(mem_data), .mem_error(mem_error),
    .busy(busy), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a, input logic [EW-1:0] x);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < 16; i++)
      if (i <= int'(x)) w[i*8 +: 8] = 8'(int'(a) + i);
    return w;
  endfunction

  // Registered ROM: samples the arbiter's mem_* at each edge, answers one edge later.
  always @(posedge clk) begin
    mem_data  <= rom_word(mem_addr, mem_extra);
    mem_error <= (mem_addr < mem_lower_bound) || (mem_addr > mem_upper_bound);
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until the port's ack is seen, bounded at 10.
  task automatic wait_ack(input bit port, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? p1_ack : p0_ack) && n < 10);
  endtask

  initial begin
    bit rr;
    logic e0, e1;
`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    reset    = 1'b1;
    p0_req   = 1'b1;  p1_req   = 1'b1;
    p0_addr  = 7'd4;  p1_addr  = 7'd8;
    p0_extra = '0;    p1_extra = '0;
    p0_lower = 7'd0;  p1_lower = 7'd0;
    p0_upper = 7'd127; p1_upper = 7'd127;

    // Reset held 3 cycles with both requests high.
    repeat (3) @(negedge clk);
    check("rst_busy", DW'(busy), 0);
    check("rst_acks", DW'({p0_ack, p1_ack}), 0);
    check("rst_grant", DW'(grant), 0);
    check("rst_mem", DW'({mem_addr, mem_extra, mem_lower_bound, mem_upper_bound}), 0);
    check("rst_p0", DW'({p0_data, p0_error}), 0);
    check("rst_p1", DW'({p1_data, p1_error}), 0);

    // Release: port 0 wins the first tie.
    reset = 1'b0;
    @(negedge clk);
    check("first_grant", DW'(grant), 0);
    check("first_busy", DW'(busy), 1);
    check("first_mem_addr", DW'(mem_addr), 4);
    p1_req = 1'b0;
    wait_ack(1'b0, lat);
    check("first_lat", DW'(lat), 2);
    check("first_data", DW'(p0_data[7:0]), 8'h04);
    p0_req = 1'b0;
    @(negedge clk);
    check("first_ack_pulse", DW'(p0_ack), 0);
    check("first_idle", DW'(busy), 0);

    // Single read of addr 17; port 1 outputs untouched.
    p0_addr = 7'd17;
    p0_req  = 1'b1;
    wait_ack(1'b0, lat);
    check("single_lat", DW'(lat), 3);
    check("single_data", DW'(p0_data[7:0]), 8'h11);
    check("single_err", DW'(p0_error), 0);
    check("single_p1_hold", DW'({p1_data, p1_error, p1_ack}), 0);
    p0_req = 1'b0;
    @(negedge clk);
    check("single_ack_pulse", DW'(p0_ack), 0);

    // Field change after grant: addr 17 -> 30 has no effect.
    p0_req = 1'b1;
    @(negedge clk);
    p0_addr  = 7'd30;
    p0_extra = 4'd3;
    wait_ack(1'b0, lat);
    check("latch_lat", DW'(lat), 2);
    check("latch_mem_addr", DW'(mem_addr), 17);
    check("latch_data", p0_data, rom_word(7'd17, 4'd0));
    p0_req   = 1'b0;
    p0_extra = '0;
    @(negedge clk);

    // Bounds error on port 1: addr 20, upper 10.
    p1_addr  = 7'd20;
    p1_upper = 7'd10;
    p1_req   = 1'b1;
    @(negedge clk);
    check("bnd_grant", DW'(grant), 1);
    check("bnd_upper", DW'(mem_upper_bound), 10);
    wait_ack(1'b1, lat);
    check("bnd_lat", DW'(lat), 2);
    check("bnd_err", DW'(p1_error), 1);
    check("bnd_p0_hold", DW'({p0_error, p0_data[7:0], p0_ack}), DW'({1'b0, 8'h11, 1'b0}));
    p1_req   = 1'b0;
    p1_upper = 7'd127;
    @(negedge clk);
    check("bnd_ack_pulse", DW'(p1_ack), 0);

    // Both requests held continuously.
    p0_addr = 7'd4;
    p1_addr = 7'd8;
    p0_req  = 1'b1;
    p1_req  = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      e0 = rr ? (c == 3 || c == 9) : (c % 4 == 3);
      e1 = rr ? (c == 6 || c == 12) : 1'b0;
      check($sformatf("tie_ack0_c%0d", c), DW'(p0_ack), DW'(e0));
      check($sformatf("tie_ack1_c%0d", c), DW'(p1_ack), DW'(e1));
      if (e0) check($sformatf("tie_d0_c%0d", c), DW'(p0_data[7:0]), 8'h04);
      if (e1) check($sformatf("tie_d1_c%0d", c), DW'(p1_data[7:0]), 8'h08);
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    repeat (2) @(negedge clk);
    check("tie_idle", DW'(busy), 0);

    // Reset asserted during WAIT: no ack, data cleared, retry completes.
    p0_addr = 7'd17;
    p0_req  = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_busy_wait", DW'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_busy_rst", DW'(busy), 0);
    check("mid_data_rst", DW'(p0_data), 0);
    @(negedge clk);
    check("mid_no_ack", DW'({p0_ack, p1_ack}), 0);
    reset = 1'b0;
    wait_ack(1'b0, lat);
    check("mid_retry_lat", DW'(lat), 3);
    check("mid_retry_data", DW'(p0_data[7:0]), 8'h11);
    p0_req = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
